// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

    // Main FSM states. With a 4-bit register, some encodings are left unused.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate extender format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALUOp from the main FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath mux selects
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    // Immediate format chosen purely from the opcode
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: imm_sel = IMM_I;
            OP_STORE:          imm_sel = IMM_S;
            OP_BRANCH:         imm_sel = IMM_B;
            OP_JAL:            imm_sel = IMM_J;
            default:           imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALU operation.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch math, funct3 decode for ALU instructions
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control unit: Moore main FSM, ALU decoder and immediate
// select. Optional macro CTRL_ILLEGAL_TRAP_EN sends unknown opcodes to a
// sticky TRAP state that raises illegal_instr; without it they are NOPs.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned RESET_STATE_W = 4  // must be at least 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] Immsrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal_instr
);

    logic [RESET_STATE_W-1:0] state_r;
    logic [RESET_STATE_W-1:0] state_nxt;
    state_t                   state;
    state_t                   next_s;
    logic                     state_ok;
    logic [1:0]               aluop;
    logic                     branch;
    logic                     pcupdate;

    // View the raw register as a state; any bit above the enum marks it invalid
    always_comb begin
        state    = state_t'(state_r[3:0]);
        state_ok = ((state_r >> 4) == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        state_r <= state_nxt;
    end

    // Next-state logic; reset and unused encodings both land in FETCH
    always_comb begin
        next_s = FETCH;
        if (!reset && state_ok) begin
            case (state)
                FETCH:    next_s = mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: next_s = MEMADR;
                        OP_RTYPE:          next_s = EXECR;
                        OP_ITYPE:          next_s = EXECI;
                        OP_BRANCH:         next_s = BEQ;
                        OP_JAL:            next_s = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:           next_s = TRAP;
`else
                        default:           next_s = FETCH;
`endif
                    endcase
                end
                MEMADR:   next_s = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  next_s = mem_ready ? MEMWB : MEMREAD;
                MEMWB:    next_s = FETCH;
                MEMWRITE: next_s = mem_ready ? FETCH : MEMWRITE;
                EXECR:    next_s = ALUWB;
                EXECI:    next_s = ALUWB;
                ALUWB:    next_s = FETCH;
                BEQ:      next_s = FETCH;
                JAL:      next_s = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                TRAP:     next_s = TRAP;
`endif
                default:  next_s = FETCH;
            endcase
        end
        state_nxt      = '0;
        state_nxt[3:0] = next_s;
    end

    // Moore outputs per state; reset forces strobes low and FETCH mux selects
    always_comb begin
        aluop         = ALUOP_ADD;
        branch        = 1'b0;
        pcupdate      = 1'b0;
        AdrSrc        = ADR_PC;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        RegWrite      = 1'b0;
        illegal_instr = 1'b0;
        if (state_ok) begin
            case (state)
                FETCH: begin
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = mem_ready;
                    pcupdate  = mem_ready;
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMREAD: begin
                    AdrSrc = ADR_ALUOUT;
                end
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc   = ADR_ALUOUT;
                    MemWrite = 1'b1;
                end
                EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    aluop   = ALUOP_FUNCT;
                end
                EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    aluop   = ALUOP_FUNCT;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                end
                BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    aluop   = ALUOP_SUB;
                    branch  = 1'b1;
                end
                JAL: begin
                    ALUSrcA  = SRCA_OLDPC;
                    ALUSrcB  = SRCB_FOUR;
                    pcupdate = 1'b1;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                TRAP: begin
                    illegal_instr = 1'b1;
                end
`endif
                default: ;
            endcase
        end
        if (reset) begin
            aluop         = ALUOP_ADD;
            branch        = 1'b0;
            pcupdate      = 1'b0;
            AdrSrc        = ADR_PC;
            ALUSrcA       = SRCA_PC;
            ALUSrcB       = SRCB_FOUR;
            ResultSrc     = RES_ALURESULT;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
        PCWrite = (branch & zero) | pcupdate;
    end

    // Immediate format depends only on the opcode
    always_comb begin
        Immsrc = imm_sel(op);
    end

    riscv_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule
